// File: rtl/uc_heartbeat_watchdog.sv
// uc_heartbeat_watchdog: dual-channel heartbeat watchdog ahead of the OBC selector.
// Optional glitch filter on each heartbeat input is enabled by defining HB_GLITCH_FILTER_EN.

// One watchdog channel: synchronizer, optional filter, edge detect, supervision FSM.
module uc_heartbeat_watchdog_ch #(
   parameter int CNT_W       = 27,
   parameter int TIMEOUT     = 5_000_000,
   parameter int GRACE       = 50_000_000,
`ifdef HB_GLITCH_FILTER_EN
   parameter int FILT_LEN    = 8,
`endif
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hb,
   input  logic       pwr,
   output logic       error,
   output logic       alive,
   output logic [3:0] faults
);
   typedef enum logic [1:0] {ST_OFF, ST_GRACE, ST_RUN, ST_FAULT} state_t;
   state_t state, state_n;
   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic lvl, lvl_q, hb_edge, err_n;
   // bring the asynchronous heartbeat into the clock domain
   always_ff @(posedge clk) begin
      if (!reset) sync <= '0;
      else sync <= {sync[SYNC_STAGES-2:0], hb};
   end
`ifdef HB_GLITCH_FILTER_EN
   localparam int FW = $clog2(FILT_LEN + 1);
   logic [FW-1:0] fcnt;
   logic filt;
   // accept a new level only after it has held for FILT_LEN consecutive cycles
   always_ff @(posedge clk) begin
      if (!reset) begin
         fcnt <= '0;
         filt <= 1'b0;
      end else if (sync[SYNC_STAGES-1] == filt) begin
         fcnt <= '0;
      end else if (fcnt == FW'(FILT_LEN - 1)) begin
         fcnt <= '0;
         filt <= sync[SYNC_STAGES-1];
      end else begin
         fcnt <= fcnt + 1'b1;
      end
   end
   assign lvl = filt;
`else
   assign lvl = sync[SYNC_STAGES-1];
`endif
   // previous accepted level; any change in either direction is a heartbeat edge
   always_ff @(posedge clk) begin
      if (!reset) lvl_q <= 1'b0;
      else lvl_q <= lvl;
   end
   assign hb_edge = lvl ^ lvl_q;
   // state, counter, registered error pulse and saturating fault tally
   always_ff @(posedge clk) begin
      if (!reset) begin
         state  <= ST_OFF;
         cnt    <= '0;
         error  <= 1'b0;
         faults <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         error  <= err_n;
         faults <= faults + {3'b000, err_n && faults != 4'hF};
      end
   end
   // power loss dominates, then a heartbeat edge, then expiry of the window
   always_comb begin
      state_n = state;
      cnt_n   = '0;
      err_n   = 1'b0;
      if (!pwr) begin
         state_n = ST_OFF;
      end else begin
         case (state)
            ST_OFF:   state_n = ST_GRACE;
            ST_GRACE: begin
               if (hb_edge) state_n = ST_RUN;
               else if (cnt == CNT_W'(GRACE - 1)) begin
                  state_n = ST_FAULT;
                  err_n   = 1'b1;
               end else cnt_n = cnt + 1'b1;
            end
            ST_RUN: begin
               if (!hb_edge) begin
                  if (cnt == CNT_W'(TIMEOUT - 1)) begin
                     state_n = ST_FAULT;
                     err_n   = 1'b1;
                  end else cnt_n = cnt + 1'b1;
               end
            end
            ST_FAULT: state_n = hb_edge ? ST_RUN : ST_FAULT;
            default:  state_n = ST_OFF;
         endcase
      end
   end
   assign alive = state == ST_RUN;
endmodule

// Two independent channels, one per microcontroller.
module uc_heartbeat_watchdog #(
   parameter int CNT_W       = 27,
   parameter int TIMEOUT     = 5_000_000,
   parameter int GRACE       = 50_000_000,
`ifdef HB_GLITCH_FILTER_EN
   parameter int FILT_LEN    = 8,
`endif
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hb_u1,
   input  logic       hb_u2,
   input  logic       pwr_u1,
   input  logic       pwr_u2,
   output logic       errorUC1,
   output logic       errorUC2,
   output logic       alive_u1,
   output logic       alive_u2,
   output logic [3:0] faults_u1,
   output logic [3:0] faults_u2
);
   uc_heartbeat_watchdog_ch #(
      .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GRACE(GRACE),
`ifdef HB_GLITCH_FILTER_EN
      .FILT_LEN(FILT_LEN),
`endif
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ch1 (
      .clk(clk), .reset(reset), .hb(hb_u1), .pwr(pwr_u1),
      .error(errorUC1), .alive(alive_u1), .faults(faults_u1)
   );
   uc_heartbeat_watchdog_ch #(
      .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GRACE(GRACE),
`ifdef HB_GLITCH_FILTER_EN
      .FILT_LEN(FILT_LEN),
`endif
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ch2 (
      .clk(clk), .reset(reset), .hb(hb_u2), .pwr(pwr_u2),
      .error(errorUC2), .alive(alive_u2), .faults(faults_u2)
   );
endmodule

// File: tb/tb_uc_heartbeat_watchdog.sv
// tb_uc_heartbeat_watchdog: directed checks of uc_heartbeat_watchdog with short windows.
module tb_uc_heartbeat_watchdog;
   localparam int TIMEOUT = 16;
   localparam int GRACE   = 32;
   localparam int SYNC    = 2;
`ifdef HB_GLITCH_FILTER_EN
   localparam int FILT = 8;
   localparam int LAT  = SYNC + FILT + 1;
`else
   localparam int LAT  = SYNC + 1;
`endif
   logic clk = 1'b0, reset = 1'b0;
   logic hb_u1 = 1'b0, hb_u2 = 1'b0, pwr_u1 = 1'b0, pwr_u2 = 1'b0;
   logic errorUC1, errorUC2, alive_u1, alive_u2;
   logic [3:0] faults_u1, faults_u2;
   int n_chk = 0, n_err = 0, p1 = 0, p2 = 0;

   uc_heartbeat_watchdog #(
      .CNT_W(27), .TIMEOUT(TIMEOUT), .GRACE(GRACE),
`ifdef HB_GLITCH_FILTER_EN
      .FILT_LEN(FILT),
`endif
      .SYNC_STAGES(SYNC)
   ) dut (
      .clk(clk), .reset(reset), .hb_u1(hb_u1), .hb_u2(hb_u2),
      .pwr_u1(pwr_u1), .pwr_u2(pwr_u2), .errorUC1(errorUC1), .errorUC2(errorUC2),
      .alive_u1(alive_u1), .alive_u2(alive_u2), .faults_u1(faults_u1), .faults_u2(faults_u2)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (errorUC1) p1++;
      if (errorUC2) p2++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   initial begin
      tick(3);
      chk("rst_err1", errorUC1, 0);
      chk("rst_alive1", alive_u1, 0);
      chk("rst_faults1", faults_u1, 0);
      chk("rst_faults2", faults_u2, 0);
      reset = 1'b1;
      tick(2);
      chk("off_alive1", alive_u1, 0);
      // powered with healthy heartbeat every 10 cycles
      pwr_u1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         hb_u1 = ~hb_u1;
         tick(10);
      end
      chk("run_alive1", alive_u1, 1);
      chk("run_pulses1", p1, 0);
      chk("run_faults1", faults_u1, 0);
      // heartbeat stops: pulse TIMEOUT cycles after the last accepted edge
      tick(LAT + 15 - 10);
      chk("to_early", errorUC1, 0);
      tick(1);
      chk("to_pulse", errorUC1, 1);
      tick(1);
      chk("to_single", errorUC1, 0);
      chk("to_alive", alive_u1, 0);
      chk("to_faults", faults_u1, 1);
      // recovery from FAULT on the next edge
      hb_u1 = ~hb_u1;
      tick(LAT - 1);
      chk("rec_before", alive_u1, 0);
      tick(1);
      chk("rec_alive", alive_u1, 1);
      chk("rec_pulses", p1, 1);
      // power cycle then stuck heartbeat: grace expiry
      pwr_u1 = 1'b0;
      tick(1);
      chk("off_again", alive_u1, 0);
      pwr_u1 = 1'b1;
      tick(32);
      chk("grace_early", errorUC1, 0);
      tick(1);
      chk("grace_pulse", errorUC1, 1);
      chk("grace_faults", faults_u1, 2);
      // channel 2: power removed on the very cycle its timeout would expire
      pwr_u2 = 1'b1;
      hb_u2 = 1'b1;
      tick(LAT);
      chk("ch2_alive", alive_u2, 1);
      tick(15);
      pwr_u2 = 1'b0;
      tick(1);
      chk("ch2_pwr_err", errorUC2, 0);
      chk("ch2_off", alive_u2, 0);
      tick(20);
      chk("ch2_no_pulse", p2, 0);
      pwr_u2 = 1'b1;
      tick(32);
      chk("ch2_grace_early", errorUC2, 0);
      tick(1);
      chk("ch2_grace_pulse", errorUC2, 1);
      chk("ch2_faults", faults_u2, 1);
      chk("ch1_indep", faults_u1, 2);
      // edge lands on the exact expiry cycle: edge wins
      hb_u1 = ~hb_u1;
      tick(16);
      hb_u1 = ~hb_u1;
      tick(3);
      chk("tie_err", errorUC1, 0);
      chk("tie_alive", alive_u1, 1);
      tick(1);
      chk("tie_pulses", p1, 2);
      // saturation of the fault tally
      for (int i = 0; i < 13; i++) begin
         pwr_u1 = 1'b0;
         tick(1);
         pwr_u1 = 1'b1;
         tick(40);
      end
      chk("sat_reach", faults_u1, 15);
      for (int i = 0; i < 2; i++) begin
         pwr_u1 = 1'b0;
         tick(1);
         pwr_u1 = 1'b1;
         tick(40);
      end
      chk("sat_hold", faults_u1, 15);
      chk("sat_pulses", p1, 17);
      // reset on the expiry cycle drops the pending pulse
      pwr_u1 = 1'b0;
      tick(1);
      pwr_u1 = 1'b1;
      tick(32);
      reset = 1'b0;
      hb_u1 = 1'b0;
      hb_u2 = 1'b0;
      pwr_u2 = 1'b0;
      tick(1);
      chk("mid_rst_err", errorUC1, 0);
      chk("mid_rst_faults1", faults_u1, 0);
      chk("mid_rst_faults2", faults_u2, 0);
      reset = 1'b1;
      tick(32);
      chk("post_rst_early", errorUC1, 0);
      tick(1);
      chk("post_rst_pulse", errorUC1, 1);
      chk("post_rst_faults", faults_u1, 1);
`ifdef HB_GLITCH_FILTER_EN
      // short glitch is filtered out, long toggle is accepted
      hb_u1 = 1'b1;
      tick(LAT);
      chk("flt_alive", alive_u1, 1);
      tick(2);
      hb_u1 = 1'b0;
      tick(3);
      hb_u1 = 1'b1;
      tick(10);
      chk("flt_early", errorUC1, 0);
      tick(1);
      chk("flt_pulse", errorUC1, 1);
      chk("flt_faults", faults_u1, 2);
      hb_u1 = 1'b0;
      tick(LAT - 1);
      chk("flt_before", alive_u1, 0);
      tick(1);
      chk("flt_accept", alive_u1, 1);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
